game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 154 +++++++++++++++
 tb/tb_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game-flow controller: IDLE/PLAY/DYING/OVER FSM, flap edge detect, BCD pipe-pass scoring.
// Define GAME_CTRL_HIGH_SCORE_EN to add the best_bcd high-score port and register.
module game_ctrl #(
  parameter int PIPE_W     = 80,
  parameter int DIE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_flap,
  input  logic        collision,
  input  logic [11:0] bird_x,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe2_x,
  output logic [1:0]  state,
  output logic        game_run,
  output logic        flap_pulse,
  output logic [11:0] score_bcd
`ifdef GAME_CTRL_HIGH_SCORE_EN
  ,
  output logic [11:0] best_bcd
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int               CNT_W    = $clog2(DIE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DIE_LAST = CNT_W'(DIE_FRAMES - 1);
  localparam logic [12:0]      PIPE_W13 = 13'(PIPE_W);

  state_e           state_q;
  state_e           state_d;
  logic             btn_q;
  logic             rise;
  logic             passed1;
  logic             passed2;
  logic [CNT_W-1:0] die_cnt;
  logic             pass1;
  logic             pass2;
  logic             new1;
  logic             new2;
  logic             resp1;
  logic             resp2;
  logic [11:0]      score_inc1;
  logic [11:0]      score_inc2;

  // One-step BCD increment with digit carry; 999 is sticky.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign rise = btn_flap & ~btn_q;

  // Widened to 13 bits so a pipe near the right edge cannot wrap into a pass.
  assign pass1 = ({1'b0, pipe1_x} + PIPE_W13) < {1'b0, bird_x};
  assign pass2 = ({1'b0, pipe2_x} + PIPE_W13) < {1'b0, bird_x};
  assign resp1 = pipe1_x >= bird_x;
  assign resp2 = pipe2_x >= bird_x;
  assign new1  = pass1 & ~passed1;
  assign new2  = pass2 & ~passed2;

  assign score_inc1 = bcd_inc(score_bcd);
  assign score_inc2 = bcd_inc(score_inc1);

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rise) state_d = PLAY;
      PLAY:  if (collision) state_d = DYING;
      DYING: if (frame_tick && die_cnt == DIE_LAST) state_d = OVER;
      OVER:  if (rise) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      btn_q      <= 1'b0;
      game_run   <= 1'b0;
      flap_pulse <= 1'b0;
      score_bcd  <= 12'h000;
      passed1    <= 1'b0;
      passed2    <= 1'b0;
      die_cnt    <= '0;
`ifdef GAME_CTRL_HIGH_SCORE_EN
      best_bcd   <= 12'h000;
`endif
    end else begin
      // NOTE: non-blocking everywhere here so every register sees pre-edge values.
      btn_q      <= btn_flap;
      state_q    <= state_d;
      game_run   <= (state_d == PLAY);
      flap_pulse <= rise && (state_q == IDLE || state_q == PLAY);

      unique case (state_q)
        IDLE: begin
          if (rise) begin
            score_bcd <= 12'h000;
            passed1   <= 1'b0;
            passed2   <= 1'b0;
          end
        end
        PLAY: begin
          // Collision takes priority over any scoring on the same cycle.
          if (collision) begin
            die_cnt <= '0;
          end else if (frame_tick) begin
            if (new1)       passed1 <= 1'b1;
            else if (resp1) passed1 <= 1'b0;
            if (new2)       passed2 <= 1'b1;
            else if (resp2) passed2 <= 1'b0;
            if (new1 && new2)      score_bcd <= score_inc2;
            else if (new1 || new2) score_bcd <= score_inc1;
          end
        end
        DYING: begin
          if (frame_tick) die_cnt <= die_cnt + CNT_W'(1);
        end
        OVER: begin
        end
      endcase

`ifdef GAME_CTRL_HIGH_SCORE_EN
      // BCD digits compare correctly as plain unsigned values.
      if (state_q == DYING && state_d == OVER && score_bcd > best_bcd)
        best_bcd <= score_bcd;
`endif
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed game scenarios plus random play against a rule-level model.
module tb_game_ctrl;

  localparam int PIPE_W     = 80;
  localparam int DIE_FRAMES = 60;
  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_OVER = 3;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        btn_flap;
  logic        collision;
  logic [11:0] bird_x;
  logic [11:0] pipe1_x;
  logic [11:0] pipe2_x;
  logic [1:0]  state;
  logic        game_run;
  logic        flap_pulse;
  logic [11:0] score_bcd;
`ifdef GAME_CTRL_HIGH_SCORE_EN
  logic [11:0] best_bcd;
`endif

  game_ctrl #(.PIPE_W(PIPE_W), .DIE_FRAMES(DIE_FRAMES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_flap   (btn_flap),
    .collision  (collision),
    .bird_x     (bird_x),
    .pipe1_x    (pipe1_x),
    .pipe2_x    (pipe2_x),
    .state      (state),
    .game_run   (game_run),
    .flap_pulse (flap_pulse),
    .score_bcd  (score_bcd)
`ifdef GAME_CTRL_HIGH_SCORE_EN
    ,
    .best_bcd   (best_bcd)
`endif
  );

  typedef struct packed {
    logic [1:0]  st;
    logic        run;
    logic        flap;
    logic [11:0] score;
    logic [11:0] best;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game rules in plain integers.
  int m_state = S_IDLE;
  bit m_btn   = 1'b0;
  int m_score = 0;
  int m_best  = 0;
  int m_die   = 0;
  bit m_pass[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int s);
    return {4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_state   = S_IDLE;
    m_btn     = 1'b0;
    m_score   = 0;
    m_best    = 0;
    m_die     = 0;
    m_pass[0] = 1'b0;
    m_pass[1] = 1'b0;
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cycle(input bit f, input bit b, input bit c, input int bx, input int p1, input int p2);
    exp_t e;
    bit   rise;
    int   nxt;
    int   p[2];
    @(negedge clk);
    frame_tick = f;
    btn_flap   = b;
    collision  = c;
    bird_x     = 12'(bx);
    pipe1_x    = 12'(p1);
    pipe2_x    = 12'(p2);
    p[0] = p1;
    p[1] = p2;
    rise   = b && !m_btn;
    e.flap = rise && (m_state == S_IDLE || m_state == S_PLAY);
    nxt    = m_state;
    case (m_state)
      S_IDLE: if (rise) begin
        nxt       = S_PLAY;
        m_score   = 0;
        m_pass[0] = 1'b0;
        m_pass[1] = 1'b0;
      end
      S_PLAY: begin
        if (c) begin
          nxt   = S_DYING;
          m_die = 0;
        end else if (f) begin
          for (int i = 0; i < 2; i++) begin
            if (p[i] + PIPE_W < bx) begin
              if (!m_pass[i]) begin
                m_pass[i] = 1'b1;
                m_score++;
              end
            end else if (p[i] >= bx) begin
              m_pass[i] = 1'b0;
            end
          end
          if (m_score > 999) m_score = 999;
        end
      end
      S_DYING: if (f) begin
        m_die++;
        if (m_die == DIE_FRAMES) begin
          nxt = S_OVER;
          if (m_score > m_best) m_best = m_score;
        end
      end
      default: if (rise) nxt = S_IDLE;
    endcase
    m_state = nxt;
    m_btn   = b;
    e.st    = 2'(m_state);
    e.run   = (m_state == S_PLAY);
    e.score = to_bcd(m_score);
    e.best  = to_bcd(m_best);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("game_run", 32'(game_run), 32'(e.run));
      check("flap_pulse", 32'(flap_pulse), 32'(e.flap));
      check("score_bcd", 32'(score_bcd), 32'(e.score));
`ifdef GAME_CTRL_HIGH_SCORE_EN
      check("best_bcd", 32'(best_bcd), 32'(e.best));
`endif
    end
  end

  task automatic tick(input int p1, input int p2);
    cycle(1'b1, 1'b0, 1'b0, 200, p1, p2);
  endtask

  task automatic press();
    cycle(1'b0, 1'b1, 1'b0, 200, 700, 700);
    cycle(1'b0, 1'b0, 1'b0, 200, 700, 700);
  endtask

  task automatic pass_one();
    tick(700, 700);
    tick(100, 700);
  endtask

  task automatic pass_both();
    tick(700, 700);
    tick(100, 100);
  endtask

  // Collision on a passing tick, then the full dying count with button rises sprinkled in.
  task automatic die_out();
    tick(700, 700);
    cycle(1'b1, 1'b0, 1'b1, 200, 100, 700);
    for (int i = 0; i < DIE_FRAMES; i++) begin
      cycle(1'b1, i[0], 1'b0, 200, 700, 700);
      cycle(1'b0, 1'b0, 1'b0, 200, 700, 700);
    end
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_flap   = 1'b0;
    collision  = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_game_run", 32'(game_run), 32'd0);
    check("rst_flap_pulse", 32'(flap_pulse), 32'd0);
    check("rst_score_bcd", 32'(score_bcd), 32'd0);
`ifdef GAME_CTRL_HIGH_SCORE_EN
    check("rst_best_bcd", 32'(best_bcd), 32'd0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_flap   = 1'b0;
    collision  = 1'b0;
    bird_x     = 12'd200;
    pipe1_x    = 12'd700;
    pipe2_x    = 12'd700;
    model_reset();

    do_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 200, 700, 700);
    press();
    tick(150, 700);
    tick(119, 700);
    repeat (3) tick(100, 700);
    tick(700, 700);
    tick(119, 700);
    tick(4090, 700);
    tick(100, 700);
    while (m_score < 99) pass_one();
    pass_one();
    die_out();
    press();
    press();
    repeat (8) pass_one();
    pass_both();
    while (m_score < 999) pass_both();
    repeat (3) pass_both();
    die_out();
    press();

    do_reset();
    press();
    repeat (5) pass_one();
    die_out();
    press();
    press();
    repeat (3) pass_one();
    die_out();
    press();
    press();
    pass_one();
    pass_one();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      int bx;
      int p1;
      int p2;
      bx = 150 + int'($urandom_range(0, 99));
      p1 = ($urandom_range(0, 7) == 0) ? 4000 + int'($urandom_range(0, 95)) : int'($urandom_range(0, 399));
      p2 = ($urandom_range(0, 7) == 0) ? 4000 + int'($urandom_range(0, 95)) : int'($urandom_range(0, 399));
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), bx, p1, p2);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
